// File: rtl/gmii_tx_framer_if.sv
// Byte-stream source and GMII transmit bus of the framer.
//   s_data/s_valid/s_last/s_err : payload bytes from the MAC client
//   s_ready                     : byte accepted when s_valid & s_ready
//   tx_data/tx_en/tx_er         : registered GMII transmit outputs
// master = client/observer side, slave = framer side.
interface gmii_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_err;
    logic       s_ready;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_er;

    modport master (
        output s_data, s_valid, s_last, s_err,
        input  s_ready, tx_data, tx_en, tx_er
    );

    modport slave (
        input  s_data, s_valid, s_last, s_err,
        output s_ready, tx_data, tx_en, tx_er
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a payload byte stream with preamble, SFD,
// zero padding up to MIN_FRAME bytes, CRC-32 FCS and an enforced
// inter-frame gap. All GMII outputs are registered for the DDR pin stage.
//   tx_clk        : 125 MHz transmit clock, rising edge
//   rst_n         : asynchronous active-low reset
//   bus           : payload stream in, GMII tx_data/tx_en/tx_er out
//   busy_o        : state is not IDLE
//   frame_done_o  : pulse alongside the last FCS byte
//   frame_abort_o : pulse alongside the tx_er byte of an aborted frame
//
// state | meaning
// IDLE  | line quiet, waiting for s_valid
// PRE   | emitting 0x55 preamble bytes
// SFD   | emitting 0xD5, CRC and byte counter re-initialised
// DATA  | s_ready high, each accepted byte emitted on the next cycle
// PAD   | emitting 0x00 fill until MIN_FRAME bytes
// FCS   | emitting ~crc, least-significant byte first
// IFG   | line quiet for the inter-frame gap
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic            tx_clk,
    input  logic            rst_n,
    gmii_tx_framer_if.slave bus,
    output logic            busy_o,
    output logic            frame_done_o,
    output logic            frame_abort_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);
    localparam logic [16:0] MIN_W    = 17'(MIN_FRAME);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] byte_cnt_q;
    logic [31:0] crc_q;
    logic [7:0]  tx_data_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic        done_q;
    logic        abort_q;

    logic [31:0] crc_d;
    logic [16:0] byte_cnt_d;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0000_0000);
        end
        return r;
    endfunction

    // CRC is fed the payload byte in DATA and the zero fill byte in PAD.
    always_comb begin
        crc_d      = crc_next(crc_q, (state_q == S_DATA) ? bus.s_data : 8'h00);
        byte_cnt_d = {1'b0, byte_cnt_q} + 17'd1;
    end

    // Each edge registers the byte for the next cycle; outputs default to idle.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            byte_cnt_q <= 16'd0;
            crc_q      <= 32'hFFFF_FFFF;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.s_valid) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= 8'h55;
                        cnt_q     <= 8'd0;
                        state_q   <= (PRE_LAST == 8'd0) ? S_SFD : S_PRE;
                    end
                end
                S_PRE: begin
                    // cnt_q holds preamble bytes already emitted minus one.
                    tx_en_q   <= 1'b1;
                    tx_data_q <= 8'h55;
                    cnt_q     <= cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == PRE_LAST) state_q <= S_SFD;
                end
                S_SFD: begin
                    tx_en_q    <= 1'b1;
                    tx_data_q  <= 8'hD5;
                    crc_q      <= 32'hFFFF_FFFF;
                    byte_cnt_q <= 16'd0;
                    state_q    <= S_DATA;
                end
                S_DATA: begin
                    tx_en_q <= 1'b1;
                    if (!bus.s_valid) begin
                        // Underrun: the frame cannot be completed on the wire.
                        tx_er_q <= 1'b1;
                        abort_q <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= S_IFG;
                    end else begin
                        tx_data_q <= bus.s_data;
                        if (bus.s_err) begin
                            tx_er_q <= 1'b1;
                            abort_q <= 1'b1;
                            cnt_q   <= 8'd0;
                            state_q <= S_IFG;
                        end else begin
                            crc_q <= crc_d;
                            if (byte_cnt_d <= MIN_W) byte_cnt_q <= byte_cnt_d[15:0];
                            if (bus.s_last) begin
                                cnt_q   <= 8'd0;
                                state_q <= (byte_cnt_d < MIN_W) ? S_PAD : S_FCS;
                            end
                        end
                    end
                end
                S_PAD: begin
                    tx_en_q    <= 1'b1;
                    crc_q      <= crc_d;
                    byte_cnt_q <= byte_cnt_d[15:0];
                    if (byte_cnt_d >= MIN_W) state_q <= S_FCS;
                end
                S_FCS: begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_q     <= cnt_q + 8'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        done_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= S_IFG;
                    end
                end
                S_IFG: begin
                    // IFG_BYTES+1 quiet cycles including the IDLE cycle that follows.
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == IFG_LAST) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = (state_q == S_DATA);
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_en     = tx_en_q;
    assign bus.tx_er     = tx_er_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = done_q;
    assign frame_abort_o = abort_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: a default instance and a
// MIN_FRAME=0 instance share one stimulus stream; sel0 chooses which
// instance the driver handshakes with and the monitor observes.
module tb_gmii_tx_framer;
    localparam int PRE  = 7;
    localparam int MINF = 60;
    localparam int IFG  = 12;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
        logic       done;
        logic       abort;
    } ent_t;

    logic tx_clk = 1'b0;
    logic rst_n  = 1'b0;
    logic sel0   = 1'b0;
    always #4 tx_clk = ~tx_clk;

    gmii_tx_framer_if ifd ();
    gmii_tx_framer_if if0 ();

    logic busy_d, done_d, abort_d;
    logic busy_z, done_z, abort_z;

    gmii_tx_framer dut (
        .tx_clk        (tx_clk),
        .rst_n         (rst_n),
        .bus           (ifd.slave),
        .busy_o        (busy_d),
        .frame_done_o  (done_d),
        .frame_abort_o (abort_d)
    );

    gmii_tx_framer #(.MIN_FRAME(0)) dut0 (
        .tx_clk        (tx_clk),
        .rst_n         (rst_n),
        .bus           (if0.slave),
        .busy_o        (busy_z),
        .frame_done_o  (done_z),
        .frame_abort_o (abort_z)
    );

    assign if0.s_data  = ifd.s_data;
    assign if0.s_valid = ifd.s_valid;
    assign if0.s_last  = ifd.s_last;
    assign if0.s_err   = ifd.s_err;

    wire [7:0] m_data  = sel0 ? if0.tx_data : ifd.tx_data;
    wire       m_en    = sel0 ? if0.tx_en   : ifd.tx_en;
    wire       m_er    = sel0 ? if0.tx_er   : ifd.tx_er;
    wire       m_done  = sel0 ? done_z      : done_d;
    wire       m_abort = sel0 ? abort_z     : abort_d;
    wire       m_rdy   = sel0 ? if0.s_ready : ifd.s_ready;

    ent_t exp_q[$];
    int   gaps[$];
    int   lens[$];
    int   checks    = 0;
    int   fails     = 0;
    int   done_cnt  = 0;
    int   abort_cnt = 0;

    logic [7:0] t1 [21] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                            8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                            8'h26, 8'h39, 8'hF4, 8'hCB};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push(input logic [7:0] d, input logic er, input logic dn, input logic ab);
        ent_t e;
        e.d = d; e.er = er; e.done = dn; e.abort = ab;
        exp_q.push_back(e);
    endtask

    // ab_kind: 0 good frame, 1 s_err at ab_idx, 2 underrun at ab_idx
    task automatic expect_frame(input logic [7:0] pl[$], input int minf,
                                input int ab_kind, input int ab_idx);
        logic [31:0] c;
        int n;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < PRE; i++) push(8'h55, 1'b0, 1'b0, 1'b0);
        push(8'hD5, 1'b0, 1'b0, 1'b0);
        if (ab_kind != 0) begin
            for (int i = 0; i < ab_idx; i++) push(pl[i], 1'b0, 1'b0, 1'b0);
            push((ab_kind == 1) ? pl[ab_idx] : 8'h00, 1'b1, 1'b0, 1'b1);
            return;
        end
        foreach (pl[i]) begin
            push(pl[i], 1'b0, 1'b0, 1'b0);
            c = crc_upd(c, pl[i]);
        end
        n = pl.size();
        while (n < minf) begin
            push(8'h00, 1'b0, 1'b0, 1'b0);
            c = crc_upd(c, 8'h00);
            n++;
        end
        c = ~c;
        push(c[7:0],   1'b0, 1'b0, 1'b0);
        push(c[15:8],  1'b0, 1'b0, 1'b0);
        push(c[23:16], 1'b0, 1'b0, 1'b0);
        push(c[31:24], 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [7:0] pl[$], input int gap_idx, input int err_idx);
        int  i;
        int  budget;
        bit  gap_done;
        logic rdy;
        i = 0; budget = 0; gap_done = 1'b0;
        while (i < pl.size() && budget < 2000) begin
            @(negedge tx_clk);
            rdy = m_rdy;
            budget++;
            if (rdy && i == gap_idx && !gap_done) begin
                ifd.s_valid = 1'b0;
                gap_done = 1'b1;
                @(posedge tx_clk);
                return;
            end
            ifd.s_valid = 1'b1;
            ifd.s_data  = pl[i];
            ifd.s_last  = (i == pl.size() - 1);
            ifd.s_err   = (i == err_idx);
            @(posedge tx_clk);
            if (rdy) begin
                if (i == err_idx) begin
                    @(negedge tx_clk);
                    chk("s_ready_after_err", {31'd0, m_rdy}, 32'd0);
                    return;
                end
                i++;
            end
        end
        if (i < pl.size()) begin
            checks++; fails++;
            $display("FAIL send_timeout: sent %0d, expected %0d bytes", i, pl.size());
        end
    endtask

    task automatic idle();
        @(negedge tx_clk);
        ifd.s_valid = 1'b0;
        ifd.s_last  = 1'b0;
        ifd.s_err   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_d || busy_z || m_en) && n < 4000) begin
            @(negedge tx_clk);
            n++;
        end
        if (n >= 4000) begin
            checks++; fails++;
            $display("FAIL idle_timeout: %0d scoreboard entries left, expected 0", exp_q.size());
        end
        repeat (3) @(negedge tx_clk);
    endtask

    task automatic clear_stats();
        gaps.delete();
        lens.delete();
    endtask

    // Monitor: pops one expected entry per tx_en-high cycle.
    initial begin : monitor
        int   low_cnt;
        int   high_cnt;
        bit   prev_en;
        ent_t e;
        low_cnt = 0; high_cnt = 0; prev_en = 1'b0;
        forever begin
            @(negedge tx_clk);
            if (!rst_n) begin
                prev_en = 1'b0; low_cnt = 0; high_cnt = 0;
                continue;
            end
            if (m_done)  done_cnt++;
            if (m_abort) abort_cnt++;
            if (m_en) begin
                if (!prev_en) begin
                    gaps.push_back(low_cnt);
                    high_cnt = 0;
                end
                high_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no tx_en", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {21'd0, m_data, m_er, m_done, m_abort}, {21'd0, e});
                end
            end else begin
                if (prev_en) begin
                    lens.push_back(high_cnt);
                    low_cnt = 0;
                end
                low_cnt++;
                chk("idle_quiet", {21'd0, m_data, m_er, m_done, m_abort}, 32'd0);
            end
            prev_en = m_en;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        int d0, a0;
        ifd.s_valid = 1'b0;
        ifd.s_data  = 8'h00;
        ifd.s_last  = 1'b0;
        ifd.s_err   = 1'b0;
        repeat (3) @(negedge tx_clk);
        chk("rst_tx_en",   {31'd0, ifd.tx_en},   32'd0);
        chk("rst_tx_er",   {31'd0, ifd.tx_er},   32'd0);
        chk("rst_tx_data", {24'd0, ifd.tx_data}, 32'd0);
        chk("rst_busy",    {31'd0, busy_d},      32'd0);
        chk("rst_s_ready", {31'd0, ifd.s_ready}, 32'd0);
        chk("rst_done",    {31'd0, done_d},      32'd0);
        chk("rst_abort",   {31'd0, abort_d},     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge tx_clk);

        // "123456789" with padding disabled, hand-computed FCS
        sel0 = 1'b1; clear_stats(); d0 = done_cnt;
        for (int i = 0; i < 21; i++) push(t1[i], 1'b0, (i == 20), 1'b0);
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        send(pl, -1, -1);
        idle();
        wait_idle();
        chk("t1_len",  q_at(lens, 0), 21);
        chk("t1_done", done_cnt - d0, 1);
        sel0 = 1'b0;

        // 1-byte frame padded to 60
        clear_stats(); d0 = done_cnt;
        pl.delete(); pl.push_back(8'hAB);
        expect_frame(pl, MINF, 0, 0);
        send(pl, -1, -1);
        idle();
        wait_idle();
        chk("t2_len",  q_at(lens, 0), 72);
        chk("t2_done", done_cnt - d0, 1);

        // two 64-byte frames back to back
        clear_stats(); d0 = done_cnt;
        pl.delete(); pl2.delete();
        for (int i = 0; i < 64; i++) begin
            pl.push_back(8'(i));
            pl2.push_back(8'hA0 ^ 8'(i));
        end
        expect_frame(pl, MINF, 0, 0);
        send(pl, -1, -1);
        expect_frame(pl2, MINF, 0, 0);
        send(pl2, -1, -1);
        idle();
        wait_idle();
        chk("t3_len0", q_at(lens, 0), 76);
        chk("t3_len1", q_at(lens, 1), 76);
        chk("t3_gap",  q_at(gaps, 1), IFG + 1);
        chk("t3_done", done_cnt - d0, 2);

        // underrun at payload byte 10, then a normal frame waiting in the gap
        clear_stats(); d0 = done_cnt; a0 = abort_cnt;
        pl.delete();
        for (int i = 0; i < 30; i++) pl.push_back(8'(i * 3));
        expect_frame(pl, MINF, 2, 10);
        send(pl, 10, -1);
        expect_frame(pl2, MINF, 0, 0);
        send(pl2, -1, -1);
        idle();
        wait_idle();
        chk("t4_abort_len", q_at(lens, 0), PRE + 1 + 11);
        chk("t4_gap",       q_at(gaps, 1), IFG + 1);
        chk("t4_next_len",  q_at(lens, 1), 76);
        chk("t4_aborts",    abort_cnt - a0, 1);
        chk("t4_done",      done_cnt - d0, 1);

        // s_err on byte 20 of a 100-byte frame
        clear_stats(); d0 = done_cnt; a0 = abort_cnt;
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i + 7));
        expect_frame(pl, MINF, 1, 20);
        send(pl, -1, 20);
        idle();
        wait_idle();
        chk("t5_len",    q_at(lens, 0), PRE + 1 + 21);
        chk("t5_aborts", abort_cnt - a0, 1);
        chk("t5_done",   done_cnt - d0, 0);

        // reset asserted during PAD
        clear_stats();
        pl.delete(); pl.push_back(8'h5A);
        expect_frame(pl, MINF, 0, 0);
        send(pl, -1, -1);
        idle();
        repeat (20) @(posedge tx_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_en", {31'd0, ifd.tx_en}, 32'd0);
        chk("rst_mid_tx_er", {31'd0, ifd.tx_er}, 32'd0);
        chk("rst_mid_done",  {31'd0, done_d},    32'd0);
        chk("rst_mid_abort", {31'd0, abort_d},   32'd0);
        exp_q.delete();
        repeat (3) @(negedge tx_clk);
        rst_n = 1'b1;
        @(negedge tx_clk);
        chk("rst_rel_busy",  {31'd0, busy_d},    32'd0);
        chk("rst_rel_tx_en", {31'd0, ifd.tx_en}, 32'd0);
        clear_stats(); d0 = done_cnt;
        pl.delete();
        for (int i = 0; i < 3; i++) pl.push_back(8'(i + 1));
        expect_frame(pl, MINF, 0, 0);
        send(pl, -1, -1);
        idle();
        wait_idle();
        chk("t6_len",  q_at(lens, 0), 72);
        chk("t6_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
